// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: byte FIFO feeding a start/8N/[parity]/stop serialiser.
// Bytes written back-to-back leave the line as back-to-back frames with no idle gap.
module uart_tx_buf #(
   parameter int CLK_HZ     = 24000000,
   parameter int BAUD       = 9600,
   parameter int DEPTH      = 16,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                       clk24m,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       ovf,
   output logic                       tx_bsy,
   output logic                       txd
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      byte_q, byte_d;
   logic            txd_q, txd_d;
   logic            bsy_q, bsy_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      mem [DEPTH];
   logic            baud_end;
   logic            pop;
   logic            wr_acc;
   logic            par_bit;

   assign par_bit = (^byte_q) ^ (PARITY_ODD != 0);

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      byte_d    = byte_q;
      txd_d     = txd_q;
      bsy_d     = bsy_q;
      pop       = 1'b0;
      baud_end  = (baud_q == BAUD_LAST);
      if (state_q != S_IDLE) begin
         baud_d = baud_end ? '0 : baud_q + BW'(1);
      end
      case (state_q)
         S_IDLE: begin
            txd_d = 1'b1;
            bsy_d = 1'b0;
            if (!empty_q) begin
               pop     = 1'b1;
               byte_d  = mem[rd_ptr_q];
               txd_d   = 1'b0;
               bsy_d   = 1'b1;
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               bit_idx_d = 3'd0;
               txd_d     = byte_q[0];
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               if (bit_idx_q == 3'd7) begin
                  if (PARITY_EN != 0) begin
                     txd_d   = par_bit;
                     state_d = S_PARITY;
                  end else begin
                     txd_d   = 1'b1;
                     state_d = S_STOP;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  txd_d     = byte_q[bit_idx_q + 3'd1];
               end
            end
         end
         S_PARITY: begin
            if (baud_end) begin
               txd_d   = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               // Chain straight into the next start bit when more data is queued.
               if (!empty_q) begin
                  pop     = 1'b1;
                  byte_d  = mem[rd_ptr_q];
                  txd_d   = 1'b0;
                  state_d = S_START;
               end else begin
                  bsy_d   = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            txd_d   = 1'b1;
            bsy_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      // Write strobe: wr_dat is taken on an edge with wr_en=1 and full=0; a write
      // while full is dropped and flagged on ovf, even if a pop happens that edge.
      wr_acc   = wr_en & ~full_q;
      ovf_d    = wr_en & full_q;
      wr_ptr_d = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      case ({wr_acc, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_FULL);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk24m or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_idx_q <= 3'd0;
         byte_q    <= 8'h00;
         txd_q     <= 1'b1;
         bsy_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         byte_q    <= byte_d;
         txd_q     <= txd_d;
         bsy_q     <= bsy_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are valid.
   always_ff @(posedge clk24m) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= wr_dat;
      end
   end

   assign full   = full_q;
   assign empty  = empty_q;
   assign count  = count_q;
   assign ovf    = ovf_q;
   assign tx_bsy = bsy_q;
   assign txd    = txd_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf at DIV=8, DEPTH=4: even parity, odd parity and
// no-parity instances driven from one clock and one reset.
module tb_uart_tx_buf;

   localparam int DIV = 8;

   logic       clk24m = 1'b0;
   logic       rst    = 1'b1;
   logic       wr_en   [3];
   logic [7:0] wr_dat  [3];
   logic       full    [3];
   logic       empty   [3];
   logic [2:0] count   [3];
   logic       ovf     [3];
   logic       tx_bsy  [3];
   logic       txd     [3];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk24m = ~clk24m;

   uart_tx_buf #(.CLK_HZ(8), .BAUD(1), .DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
      .clk24m(clk24m), .rst(rst), .wr_en(wr_en[0]), .wr_dat(wr_dat[0]),
      .full(full[0]), .empty(empty[0]), .count(count[0]), .ovf(ovf[0]),
      .tx_bsy(tx_bsy[0]), .txd(txd[0]));

   uart_tx_buf #(.CLK_HZ(8), .BAUD(1), .DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
      .clk24m(clk24m), .rst(rst), .wr_en(wr_en[1]), .wr_dat(wr_dat[1]),
      .full(full[1]), .empty(empty[1]), .count(count[1]), .ovf(ovf[1]),
      .tx_bsy(tx_bsy[1]), .txd(txd[1]));

   uart_tx_buf #(.CLK_HZ(8), .BAUD(1), .DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
      .clk24m(clk24m), .rst(rst), .wr_en(wr_en[2]), .wr_dat(wr_dat[2]),
      .full(full[2]), .empty(empty[2]), .count(count[2]), .ovf(ovf[2]),
      .tx_bsy(tx_bsy[2]), .txd(txd[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk24m);
      #1;
   endtask

   task automatic write_byte(input int idx, input logic [7:0] d);
      wr_en[idx]  = 1'b1;
      wr_dat[idx] = d;
      tick();
      wr_en[idx]  = 1'b0;
   endtask

   // Checks txd clock by clock; clock 0 is the first edge of the start bit and
   // the first 'skip' clocks have already elapsed.
   task automatic check_frame(input int idx, input logic [7:0] b, input bit has_par,
                              input bit par_bit, input int skip, input string tag);
      logic [10:0] bits;
      int          nbits;
      bits[0]   = 1'b0;
      bits[8:1] = b;
      if (has_par) begin
         bits[9]  = par_bit;
         bits[10] = 1'b1;
         nbits    = 11;
      end else begin
         bits[9]  = 1'b1;
         bits[10] = 1'b1;
         nbits    = 10;
      end
      for (int c = skip; c < nbits * DIV; c++) begin
         tick();
         check($sformatf("%s_txd_c%0d", tag, c), 32'(txd[idx]), 32'(bits[c / DIV]));
         check($sformatf("%s_bsy_c%0d", tag, c), 32'(tx_bsy[idx]), 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ovf_bytes [6];
      logic       ovf_par   [5];
      logic [2:0] ovf_cnt   [6];
      bit         idle_ok;
      ovf_bytes = '{8'h11, 8'h23, 8'h35, 8'h80, 8'h5B, 8'hEE};
      ovf_par   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      ovf_cnt   = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      for (int i = 0; i < 3; i++) begin
         wr_en[i]  = 1'b0;
         wr_dat[i] = 8'h00;
      end

      // Reset, then a second reset asserted mid-idle between edges.
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      check("rst_txd",   32'(txd[0]),    32'd1);
      check("rst_bsy",   32'(tx_bsy[0]), 32'd0);
      check("rst_empty", 32'(empty[0]),  32'd1);
      check("rst_full",  32'(full[0]),   32'd0);
      check("rst_count", 32'(count[0]),  32'd0);
      check("rst_ovf",   32'(ovf[0]),    32'd0);
      @(negedge clk24m);
      rst = 1'b0;
      tick();

      // Single byte 0x07, even parity -> parity bit 1.
      write_byte(0, 8'h07);
      check("single_count", 32'(count[0]), 32'd1);
      check("single_empty", 32'(empty[0]), 32'd0);
      check_frame(0, 8'h07, 1'b1, 1'b1, 0, "single");
      tick();
      check("single_bsy_fall", 32'(tx_bsy[0]), 32'd0);
      check("single_idle_txd", 32'(txd[0]),    32'd1);
      check("single_empty_end", 32'(empty[0]), 32'd1);
      repeat (3) tick();

      // Back-to-back 0x00 then 0xFF: no gap between frames.
      write_byte(0, 8'h00);
      write_byte(0, 8'hFF);
      check("b2b_count", 32'(count[0]), 32'd1);
      check_frame(0, 8'h00, 1'b1, 1'b0, 1, "b2b0");
      check_frame(0, 8'hFF, 1'b1, 1'b0, 0, "b2b1");
      tick();
      check("b2b_bsy_fall", 32'(tx_bsy[0]), 32'd0);
      repeat (3) tick();

      // Overflow: six writes on six consecutive edges into a 4-deep FIFO.
      wr_en[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_dat[0] = ovf_bytes[i];
         tick();
         check($sformatf("ovf_count_e%0d", i + 1), 32'(count[0]), 32'(ovf_cnt[i]));
         check($sformatf("ovf_flag_e%0d", i + 1), 32'(ovf[0]), (i == 5) ? 32'd1 : 32'd0);
      end
      wr_en[0] = 1'b0;
      check("ovf_full", 32'(full[0]), 32'd1);
      tick();
      check("ovf_pulse_end", 32'(ovf[0]),  32'd0);
      check("ovf_count_e7",  32'(count[0]), 32'd4);
      check("ovf_f0_start",  32'(txd[0]),  32'd0);
      check_frame(0, ovf_bytes[0], 1'b1, ovf_par[0], 6, "ovf_f0");
      for (int i = 1; i < 5; i++) begin
         check_frame(0, ovf_bytes[i], 1'b1, ovf_par[i], 0, $sformatf("ovf_f%0d", i));
      end
      tick();
      check("ovf_bsy_fall", 32'(tx_bsy[0]), 32'd0);
      check("ovf_empty",    32'(empty[0]),  32'd1);
      check("ovf_txd_idle", 32'(txd[0]),    32'd1);
      repeat (3) tick();

      // Odd parity: 0x07 -> parity bit 0.
      write_byte(1, 8'h07);
      check_frame(1, 8'h07, 1'b1, 1'b0, 0, "odd");
      tick();
      check("odd_bsy_fall", 32'(tx_bsy[1]), 32'd0);

      // No parity: 80-clock frame, stop directly after bit 7.
      write_byte(2, 8'h07);
      check_frame(2, 8'h07, 1'b0, 1'b0, 0, "nopar");
      tick();
      check("nopar_bsy_fall", 32'(tx_bsy[2]), 32'd0);
      repeat (3) tick();

      // Reset during data bit 3 with a second byte still queued.
      write_byte(0, 8'h07);
      write_byte(0, 8'h55);
      repeat (34) tick();
      check("mid_txd_bit3",  32'(txd[0]),   32'd0);
      check("mid_count_pre", 32'(count[0]), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_txd",   32'(txd[0]),    32'd1);
      check("mid_rst_bsy",   32'(tx_bsy[0]), 32'd0);
      check("mid_rst_count", 32'(count[0]),  32'd0);
      check("mid_rst_empty", 32'(empty[0]),  32'd1);
      @(negedge clk24m);
      rst = 1'b0;
      idle_ok = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (txd[0] !== 1'b1 || tx_bsy[0] !== 1'b0) idle_ok = 1'b0;
      end
      check("post_rst_idle", 32'(idle_ok), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
